disp_arbiter: RTL and testbench
===============================

Name: disp_arbiter

Overview:
- Round-robin time-share scheduler for the 4-digit 7-segment display driver `seg`.
- Up to four requesters each offer an 8-bit value. The block grants one at a time for a fixed dwell period and drives the winner's value onto `seg`'s 8-bit `gdc` input.
- Sits between application logic (counters, switches, results) and `seg`. `seg` itself is unchanged.

Parameters:
- DWELL, default 50_000_000, meaning the number of clk cycles a grant is held (0.5 s at 100 MHz). Must be ≥ 2. Benches override to 4.
- CW, default 26, meaning the width of the dwell counter. Must satisfy 2^CW > DWELL.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  4  request vector; bit i = requester i wants the display
- d0  in  8  value from requester 0
- d1  in  8  value from requester 1
- d2  in  8  value from requester 2
- d3  in  8  value from requester 3
- hold  in  1  when 1, freezes the current grant past dwell expiry
- gdc  out  8  value to `seg` `gdc` input
- gnt  out  4  one-hot grant, all-zero when nothing is granted
- valid  out  1  1 while gnt is non-zero
- cnt_o  out  CW  current dwell count, for debug

Behaviour:
- reset low (async): state=IDLE, gnt=0, valid=0, gdc=8'h00, cnt=0, last=3. Round-robin therefore starts at requester 0.
- All outputs are registered. No combinational path from inputs to outputs.
- Round-robin pick: search req starting at (last+1) mod 4, wrapping. The first set bit wins. The current owner is checked last.
- State IDLE:
  - gnt=0, valid=0, gdc=0.
  - If req≠0 at edge k, then at edge k+1: state=DWELL, gnt=onehot(pick), valid=1, gdc=d[pick], cnt=0, last=pick.
- State DWELL:
  - Every edge: gdc <= d[g]. gdc tracks live data with 1-cycle latency.
  - cnt increments each edge and saturates at DWELL-1.
  - Exit 1, early release: req[g]=0 at an edge → next state GAP. This has priority over hold.
  - Exit 2, expiry: cnt==DWELL-1 and hold=0 → next state GAP.
  - cnt==DWELL-1 and hold=1 and req[g]=1 → stay in DWELL; cnt stays at DWELL-1 and gdc keeps tracking.
- State GAP: exactly one cycle, marks the handoff.
  - gnt=0, valid=0, gdc holds its last value (no flash to 0).
  - If req≠0: round-robin pick from last+1. The previous owner is granted again only if it is the sole requester. Go to DWELL with cnt=0 and gdc=d[pick].
  - If req==0: go to IDLE, which sets gdc=0 on the following edge.
- Invariants:
  - gnt is always one-hot or zero.
  - valid == |gnt.
  - An undecoded state recovers to IDLE.
- Simultaneous events:
  - A new request arriving during DWELL does not preempt the owner.
  - hold asserted during GAP or IDLE has no effect.
- Reset mid-DWELL: outputs clear immediately (async) and last=3.
- d inputs of non-granted requesters are ignored.

Test Plan (DWELL=4):
1. Reset, then req=4'b0001, d0=8'hF0, all held → gnt=0001 one edge after req; gdc=F0 (`seg` shows 240). GAP (gnt=0, gdc=F0) every 5th cycle, then re-grant of 0001.
2. req=4'b1011, d0=01, d1=02, d3=04 → grant order 0001, 0010, 1000, 0001… Each grant lasts 4 cycles, separated by one GAP cycle. gdc shows 01, 02, 04.
3. Owner 0 granted; drop req[0] at cnt=1 with req[2] set → GAP on the next edge, then gnt=0100. No waiting for dwell.
4. hold=1 while owner 1 has cnt=3 and req=0110 → gnt stays 0010 and cnt=3 for 10 cycles. Release hold → GAP, then gnt=0100.
5. Owner 1, d1 changes 10→11 mid-dwell → gdc=11 exactly one edge later. gnt unchanged.
6. Assert reset mid-DWELL with gnt=0100 → gnt=0, valid=0, gdc=0 without a clock edge. After release with req=1111 → first grant is 0001.

Source files
------------

// File: rtl/disp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : disp_arbiter
// Description : Round-robin time-share scheduler for the 4-digit 7-segment
//               display driver. Grants one of four requesters at a time for
//               a fixed dwell period and forwards its 8-bit value to gdc.
// Revision    : 1.0 - initial release
// ============================================================================
module disp_arbiter #(
  parameter int DWELL = 50_000_000,
  parameter int CW    = 26
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    req,
  input  logic [7:0]    d0,
  input  logic [7:0]    d1,
  input  logic [7:0]    d2,
  input  logic [7:0]    d3,
  input  logic          hold,
  output logic [7:0]    gdc,
  output logic [3:0]    gnt,
  output logic          valid,
  output logic [CW-1:0] cnt_o
);

  // Terminal dwell count; the counter saturates here.
  localparam logic [CW-1:0] C_CNT_MAX = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    gnt_q, gnt_d;
  logic          valid_q, valid_d;
  logic [7:0]    gdc_q, gdc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    last_q, last_d;

  logic [1:0]    w_pick_idx;
  logic          w_pick_vld;
  logic [1:0]    w_cand;
  logic [7:0]    w_pick_data;
  logic [7:0]    w_owner_data;

  function automatic logic [7:0] sel_data(input logic [1:0] idx,
                                          input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic [7:0] c,
                                          input logic [7:0] e);
    logic [7:0] r;
    case (idx)
      2'd0:    r = a;
      2'd1:    r = b;
      2'd2:    r = c;
      default: r = e;
    endcase
    return r;
  endfunction

  // Round-robin search from last+1; scanning far-to-near lets the nearest
  // set bit overwrite, and the previous owner (offset 4) is considered last.
  always_comb begin
    w_pick_idx = 2'd0;
    w_pick_vld = 1'b0;
    w_cand     = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      w_cand = last_q + 2'(i);
      if (req[w_cand]) begin
        w_pick_idx = w_cand;
        w_pick_vld = 1'b1;
      end
    end
  end

  // Data selection for the new winner and for the current owner.
  always_comb begin
    w_pick_data  = sel_data(w_pick_idx, d0, d1, d2, d3);
    w_owner_data = sel_data(last_q, d0, d1, d2, d3);
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    gdc_d   = gdc_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        gnt_d   = 4'b0000;
        valid_d = 1'b0;
        gdc_d   = 8'h00;
        cnt_d   = '0;
        if (w_pick_vld) begin
          state_d = ST_DWELL;
          gnt_d   = 4'b0001 << w_pick_idx;
          valid_d = 1'b1;
          gdc_d   = w_pick_data;
          last_d  = w_pick_idx;
        end
      end
      ST_DWELL: begin
        // gdc follows the owner's live value with one cycle of latency.
        gdc_d = w_owner_data;
        if (cnt_q != C_CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
        // Early release outranks hold; expiry is blocked only by hold.
        if (!req[last_q] || ((cnt_q == C_CNT_MAX) && !hold)) begin
          state_d = ST_GAP;
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
        end
      end
      ST_GAP: begin
        // gdc keeps its last value through the handoff cycle.
        gnt_d   = 4'b0000;
        valid_d = 1'b0;
        if (w_pick_vld) begin
          state_d = ST_DWELL;
          gnt_d   = 4'b0001 << w_pick_idx;
          valid_d = 1'b1;
          gdc_d   = w_pick_data;
          cnt_d   = '0;
          last_d  = w_pick_idx;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
        valid_d = 1'b0;
        gdc_d   = 8'h00;
        cnt_d   = '0;
        last_d  = 2'd3;
      end
    endcase
  end

  // State register; last resets to 3 so the first search starts at 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= 4'b0000;
      valid_q <= 1'b0;
      gdc_q   <= 8'h00;
      cnt_q   <= '0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      gdc_q   <= gdc_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign gdc   = gdc_q;
  assign gnt   = gnt_q;
  assign valid = valid_q;
  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_disp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_disp_arbiter
// Description : Directed self-checking bench for disp_arbiter (DWELL=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [7:0] d0, d1, d2, d3;
  logic       hold;
  logic [7:0] gdc;
  logic [3:0] gnt;
  logic       valid;
  logic [2:0] cnt_o;

  int vectors;
  int miscompares;

  disp_arbiter #(.DWELL(4), .CW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .d0    (d0),
    .d1    (d1),
    .d2    (d2),
    .d3    (d3),
    .hold  (hold),
    .gdc   (gdc),
    .gnt   (gnt),
    .valid (valid),
    .cnt_o (cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  // Pulse reset low for two cycles, leaving the bench at a falling edge.
  task automatic do_reset();
    reset = 1'b0;
    nxt();
    nxt();
    reset = 1'b1;
  endtask

  logic [3:0] ord_gnt [4];
  logic [7:0] ord_gdc [4];

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b0;
    req   = 4'b0000;
    d0 = 8'h00; d1 = 8'h00; d2 = 8'h00; d3 = 8'h00;
    hold  = 1'b0;
    nxt();
    nxt();

    // Reset state.
    chk("rst_gnt",   8'(gnt),   8'h00);
    chk("rst_valid", 8'(valid), 8'h00);
    chk("rst_gdc",   gdc,       8'h00);
    chk("rst_cnt",   8'(cnt_o), 8'h00);

    // Test 1: single requester, periodic GAP every 5th cycle.
    reset = 1'b1;
    nxt();
    chk("t1_idle_gnt", 8'(gnt), 8'h00);
    req = 4'b0001;
    d0  = 8'hF0;
    for (int i = 0; i < 10; i++) begin
      nxt();
      if ((i % 5) < 4) begin
        chk("t1_gnt",   8'(gnt),   8'h01);
        chk("t1_valid", 8'(valid), 8'h01);
        chk("t1_cnt",   8'(cnt_o), 8'(i % 5));
      end else begin
        chk("t1_gap_gnt",   8'(gnt),   8'h00);
        chk("t1_gap_valid", 8'(valid), 8'h00);
      end
      chk("t1_gdc", gdc, 8'hF0);
    end

    // Test 2: rotation among 0,1,3.
    do_reset();
    req = 4'b1011;
    d0 = 8'h01; d1 = 8'h02; d3 = 8'h04;
    ord_gnt[0] = 4'b0001; ord_gdc[0] = 8'h01;
    ord_gnt[1] = 4'b0010; ord_gdc[1] = 8'h02;
    ord_gnt[2] = 4'b1000; ord_gdc[2] = 8'h04;
    ord_gnt[3] = 4'b0001; ord_gdc[3] = 8'h01;
    for (int i = 0; i < 19; i++) begin
      nxt();
      if ((i % 5) < 4) begin
        chk("t2_gnt",   8'(gnt),   8'(ord_gnt[i / 5]));
        chk("t2_valid", 8'(valid), 8'h01);
      end else begin
        chk("t2_gap_gnt", 8'(gnt), 8'h00);
      end
      chk("t2_gdc", gdc, ord_gdc[i / 5]);
    end

    // Test 3: early release at cnt=1 hands over to requester 2.
    do_reset();
    req = 4'b0101;
    d0 = 8'h33; d2 = 8'h55;
    nxt();
    chk("t3_gnt0", 8'(gnt), 8'h01);
    nxt();
    chk("t3_cnt1", 8'(cnt_o), 8'h01);
    req = 4'b0100;
    nxt();
    chk("t3_gap_gnt", 8'(gnt), 8'h00);
    nxt();
    chk("t3_gnt2", 8'(gnt), 8'h04);
    chk("t3_cnt",  8'(cnt_o), 8'h00);
    chk("t3_gdc",  gdc, 8'h55);

    // Test 4: hold freezes owner 1 at cnt=3, release hands to 2.
    do_reset();
    req = 4'b0010;
    d1 = 8'h22;
    nxt(); nxt(); nxt();
    chk("t4_cnt2", 8'(cnt_o), 8'h02);
    req  = 4'b0110;
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      nxt();
      chk("t4_hold_gnt", 8'(gnt),   8'h02);
      chk("t4_hold_cnt", 8'(cnt_o), 8'h03);
    end
    hold = 1'b0;
    nxt();
    chk("t4_gap_gnt", 8'(gnt), 8'h00);
    nxt();
    chk("t4_gnt2", 8'(gnt), 8'h04);

    // Test 5: live data tracking, ignored foreign data, GAP -> IDLE.
    do_reset();
    req = 4'b0010;
    d0 = 8'h00; d1 = 8'h10;
    nxt();
    chk("t5_gdc10", gdc, 8'h10);
    d1 = 8'h11;
    d0 = 8'hAA;
    nxt();
    chk("t5_gdc11", gdc, 8'h11);
    chk("t5_gnt",   8'(gnt), 8'h02);
    req = 4'b0000;
    nxt();
    chk("t5_gap_gnt", 8'(gnt), 8'h00);
    chk("t5_gap_gdc", gdc, 8'h11);
    nxt();
    chk("t5_idle_gdc_held", gdc, 8'h11);
    nxt();
    chk("t5_idle_gdc0", gdc, 8'h00);
    hold = 1'b1;
    nxt();
    chk("t5_idle_hold_gnt", 8'(gnt), 8'h00);
    hold = 1'b0;

    // Test 6: asynchronous reset mid-dwell.
    do_reset();
    req = 4'b0100;
    d2 = 8'h77;
    nxt();
    chk("t6_gnt2", 8'(gnt), 8'h04);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_gnt",   8'(gnt),   8'h00);
    chk("t6_async_valid", 8'(valid), 8'h00);
    chk("t6_async_gdc",   gdc,       8'h00);
    req = 4'b1111;
    nxt();
    reset = 1'b1;
    nxt();
    chk("t6_first_gnt", 8'(gnt), 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
